// File: rtl/window_mac_if.sv
// Window handshake between the line buffer (master) and the MAC consumer (slave).
// Points are packed element 0 first: element e occupies bits [e*P : e*P+P-1].
interface window_mac_if #(
   parameter int point_width = 8,
   parameter int kernel_size = 2
);
   localparam int PKK = point_width * kernel_size * kernel_size;

   logic           window_rdy;
   logic [0:PKK-1] window;
   logic [0:PKK-1] filter;
   logic           en_read;
   logic           slide;

   modport master (
      output window_rdy, window, filter,
      input  en_read, slide
   );

   modport slave (
      input  window_rdy, window, filter,
      output en_read, slide
   );
endinterface

// File: rtl/window_mac.sv
// Serial k*k dot-product engine: latches each window/filter pair, accumulates one
// product per cycle and stores the result into a row-major output feature map.
module window_mac #(
   parameter int kernel_size = 2,
   parameter int data_width  = 4,
   parameter int data_height = 4,
   parameter int point_width = 8,
   parameter int acc_width   = 18
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   window_mac_if.slave wbus,
   output logic [0:acc_width*(data_width-kernel_size+1)*(data_height-kernel_size+1)-1] result,
   output logic busy,
   output logic done,
   output logic overrun
);
   localparam int KK = kernel_size * kernel_size;
   localparam int OW = data_width - kernel_size + 1;
   localparam int OH = data_height - kernel_size + 1;
   localparam int N  = OW * OH;
   localparam int P  = point_width;
   localparam int P2 = 2 * point_width;
   localparam int A  = acc_width;
   localparam int EW = (KK > 1) ? $clog2(KK) : 1;
   localparam int JW = (N > 1) ? $clog2(N) : 1;
   localparam logic [EW-1:0] E_LAST = EW'(KK - 1);
   localparam logic [JW-1:0] J_LAST = JW'(N - 1);

   typedef enum logic [2:0] {IDLE, WAIT, MAC, WRITE, REQ, DONE} state_t;

   state_t         state_reg, state_next;
   logic [P-1:0]   win_in  [KK];
   logic [P-1:0]   flt_in  [KK];
   logic [P-1:0]   win_reg [KK];
   logic [P-1:0]   flt_reg [KK];
   logic [A-1:0]   slot_reg [N];
   logic [EW-1:0]  e_reg;
   logic [JW-1:0]  j_reg;
   logic [A-1:0]   acc_reg;
   logic [P2-1:0]  prod;
   logic           en_read_reg, slide_reg, busy_reg, done_reg, overrun_reg;
   logic           start_ok, capture;

   genvar gi;
   generate
      for (gi = 0; gi < KK; gi++) begin : g_elem
         assign win_in[gi] = wbus.window[gi*P +: P];
         assign flt_in[gi] = wbus.filter[gi*P +: P];
      end
      for (gi = 0; gi < N; gi++) begin : g_slot
         assign result[gi*A +: A] = slot_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      start_ok   = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            // start takes priority over a simultaneous window_rdy
            if (start) begin
               start_ok   = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (wbus.window_rdy) begin
               capture    = 1'b1;
               state_next = MAC;
            end
         end
         MAC:     if (e_reg == E_LAST) state_next = WRITE;
         WRITE:   state_next = (j_reg == J_LAST) ? DONE : REQ;
         REQ:     state_next = WAIT;
         default: state_next = IDLE;
      endcase
   end

   assign prod = P2'(win_reg[e_reg]) * P2'(flt_reg[e_reg]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         en_read_reg <= 1'b0;
         slide_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         overrun_reg <= 1'b0;
         e_reg       <= '0;
         j_reg       <= '0;
         acc_reg     <= '0;
         for (int i = 0; i < KK; i++) begin
            win_reg[i] <= '0;
            flt_reg[i] <= '0;
         end
         for (int i = 0; i < N; i++) slot_reg[i] <= '0;
      end else begin
         state_reg   <= state_next;
         en_read_reg <= start_ok;
         slide_reg   <= (state_next == REQ);
         busy_reg    <= (state_next inside {WAIT, MAC, WRITE, REQ});
         done_reg    <= (state_next == DONE);

         if (start_ok) begin
            j_reg       <= '0;
            overrun_reg <= 1'b0;
            for (int i = 0; i < N; i++) slot_reg[i] <= '0;
         end else begin
            if (wbus.window_rdy && (state_reg inside {MAC, WRITE, REQ}))
               overrun_reg <= 1'b1;
            if (state_reg == WRITE) begin
               slot_reg[j_reg] <= acc_reg;
               if (j_reg != J_LAST) j_reg <= j_reg + 1'b1;
            end
         end

         if (capture) begin
            win_reg <= win_in;
            flt_reg <= flt_in;
            acc_reg <= '0;
            e_reg   <= '0;
         end else if (state_reg == MAC) begin
            // accumulator wraps modulo 2^A by design
            acc_reg <= acc_reg + A'(prod);
            e_reg   <= e_reg + 1'b1;
         end
      end
   end

   assign wbus.en_read = en_read_reg;
   assign wbus.slide   = slide_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign overrun      = overrun_reg;
endmodule

// File: tb/tb_window_mac.sv
// Directed bench for window_mac (k=2, 4x4 map, 9 output slots).
module tb_window_mac;
   localparam int K   = 2;
   localparam int W   = 4;
   localparam int H   = 4;
   localparam int P   = 8;
   localparam int A   = 18;
   localparam int KK  = K * K;
   localparam int N   = (W - K + 1) * (H - K + 1);
   localparam int PKK = P * KK;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [0:A*N-1] result;
   logic busy, done, overrun;

   window_mac_if #(.point_width(P), .kernel_size(K)) wif();

   window_mac #(
      .kernel_size(K), .data_width(W), .data_height(H),
      .point_width(P), .acc_width(A)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .wbus    (wif.slave),
      .result  (result),
      .busy    (busy),
      .done    (done),
      .overrun (overrun)
   );

   always #5 clock = ~clock;

   int n_assert  = 0;
   int n_fail    = 0;
   int slide_cnt = 0;
   int enr_cnt   = 0;

   always @(posedge clock) begin
      if (wif.slide === 1'b1)   slide_cnt <= slide_cnt + 1;
      if (wif.en_read === 1'b1) enr_cnt   <= enr_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [A-1:0] slot(input int j);
      return result[A*j +: A];
   endfunction

   function automatic int pt(input int j, input int e, input int salt);
      return (salt == 0) ? 255 : ((j*37 + e*11 + salt) & 255);
   endfunction

   function automatic int wt(input int j, input int e, input int salt);
      return (salt == 0) ? 255 : ((j*5 + e*29 + salt*3 + 1) & 255);
   endfunction

   function automatic logic [0:PKK-1] mkvec(input int j, input int salt, input bit is_flt);
      logic [0:PKK-1] v;
      v = '0;
      for (int e = 0; e < KK; e++)
         v[e*P +: P] = is_flt ? P'(wt(j, e, salt)) : P'(pt(j, e, salt));
      return v;
   endfunction

   function automatic logic [A-1:0] expv(input int j, input int salt);
      int s;
      s = 0;
      for (int e = 0; e < KK; e++) s += pt(j, e, salt) * wt(j, e, salt);
      return A'(s);
   endfunction

   task automatic check_idle(input string tag);
      chk1($sformatf("%s_en_read", tag), wif.en_read, 1'b0);
      chk1($sformatf("%s_slide", tag), wif.slide, 1'b0);
      chk1($sformatf("%s_busy", tag), busy, 1'b0);
      chk1($sformatf("%s_done", tag), done, 1'b0);
      chk1($sformatf("%s_overrun", tag), overrun, 1'b0);
      chk1($sformatf("%s_result_zero", tag), (result === '0), 1'b1);
   endtask

   task automatic give_vec(input logic [0:PKK-1] w, input logic [0:PKK-1] f);
      wif.window_rdy = 1'b1;
      wif.window     = w;
      wif.filter     = f;
      tick;
      wif.window_rdy = 1'b0;
      wif.window     = $urandom();
      wif.filter     = $urandom();
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk1($sformatf("%s_en_read", tag), wif.en_read, 1'b1);
      chk1($sformatf("%s_busy", tag), busy, 1'b1);
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (wif.en_read === 1'b1 || wif.slide === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick;
      end
      if (!ok) chk1("req_timeout", 1'b0, 1'b1);
   endtask

   // kind 0: plain run, 1: extra window_rdy in MAC cycle 2 of window 1, 2: reset in MAC of window 4
   task automatic serve(input int j_from, input int salt, input int kind,
                        input bit wait_first, output bit aborted);
      bit ok;
      aborted = 1'b0;
      for (int j = j_from; j < N; j++) begin
         if (j != j_from || wait_first) begin
            wait_req(ok);
            if (!ok) return;
         end
         tick;
         give_vec(mkvec(j, salt, 1'b0), mkvec(j, salt, 1'b1));
         if (kind == 1 && j == 1) begin
            tick;
            wif.window_rdy = 1'b1;
            wif.window     = mkvec(j, salt + 100, 1'b0);
            wif.filter     = mkvec(j, salt + 100, 1'b1);
            tick;
            wif.window_rdy = 1'b0;
         end
         if (kind == 2 && j == 4) begin
            tick;
            reset = 1'b0;
            #1;
            check_idle("mid_reset");
            aborted = 1'b1;
            return;
         end
      end
      for (int i = 0; i < 20 && done !== 1'b1; i++) tick;
      chk1("run_done", done, 1'b1);
      chk1("run_busy", busy, 1'b0);
   endtask

   int s_base, e_base;
   bit ab;

   initial begin
      wif.window_rdy = 1'b0;
      wif.window     = '0;
      wif.filter     = '0;

      // reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         wif.window_rdy = 1'($urandom_range(0, 1));
         start          = 1'($urandom_range(0, 1));
         wif.window     = $urandom();
         wif.filter     = $urandom();
         tick;
      end
      check_idle("in_reset");
      start          = 1'b0;
      wif.window_rdy = 1'b0;
      reset          = 1'b1;

      // ten cycles after release without start; window_rdy in IDLE must be ignored
      e_base = enr_cnt;
      for (int i = 0; i < 10; i++) begin
         wif.window_rdy = 1'($urandom_range(0, 1));
         tick;
      end
      wif.window_rdy = 1'b1;
      tick;
      wif.window_rdy = 1'b0;
      check_idle("idle10");
      chkw("idle_en_read_count", enr_cnt - e_base, 0);

      // single directed window {1,2,3,4}.{5,6,7,8} = 70, with ignored starts
      s_base = slide_cnt;
      e_base = enr_cnt;
      do_start("run1_start");
      tick;
      chk1("run1_en_read_one_cycle", wif.en_read, 1'b0);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk1("start_in_wait_en_read", wif.en_read, 1'b0);
      chk1("start_in_wait_busy", busy, 1'b1);
      give_vec({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
      for (int n = 1; n <= 6; n++) begin
         if (n == 1) start = 1'b1;
         tick;
         start = 1'b0;
         if (n == 1) chk1("start_in_mac_en_read", wif.en_read, 1'b0);
         chk1($sformatf("slide_T+%0d", n), wif.slide, (n == 5));
         chk1($sformatf("busy_T+%0d", n), busy, 1'b1);
      end
      chkw("single_slot0", 32'(slot(0)), 70);
      chk1("single_overrun", overrun, 1'b0);

      // rest of run 1 with an overrun on window 1
      serve(1, 7, 1, 1'b0, ab);
      chk1("ovr_flag", overrun, 1'b1);
      chkw("ovr_slot0_kept", 32'(slot(0)), 70);
      for (int j = 1; j < N; j++)
         chkw($sformatf("ovr_slot%0d", j), 32'(slot(j)), 32'(expv(j, 7)));
      chkw("run1_slides", slide_cnt - s_base, N - 1);
      chkw("run1_en_reads", enr_cnt - e_base, 1);
      for (int i = 0; i < 5; i++) tick;
      chkw("done_hold_slot8", 32'(slot(N-1)), 32'(expv(N-1, 7)));
      chk1("done_hold_flag", done, 1'b1);

      // restart clears overrun, done and slots; then reset during window 4
      do_start("run2_start");
      chk1("restart_overrun_clear", overrun, 1'b0);
      chk1("restart_done_clear", done, 1'b0);
      chk1("restart_result_zero", (result === '0), 1'b1);
      serve(0, 3, 2, 1'b1, ab);
      chk1("run2_aborted", ab, 1'b1);
      tick;
      tick;
      reset  = 1'b1;
      s_base = slide_cnt;
      e_base = enr_cnt;
      for (int i = 0; i < 10; i++) tick;
      chkw("post_reset_slides", slide_cnt - s_base, 0);
      chkw("post_reset_en_reads", enr_cnt - e_base, 0);
      check_idle("post_reset");

      // full run, all points and weights 255
      s_base = slide_cnt;
      e_base = enr_cnt;
      do_start("run3_start");
      serve(0, 0, 0, 1'b1, ab);
      for (int j = 0; j < N; j++)
         chkw($sformatf("max_slot%0d", j), 32'(slot(j)), 260100);
      chkw("run3_slides", slide_cnt - s_base, N - 1);
      chkw("run3_en_reads", enr_cnt - e_base, 1);
      chk1("run3_overrun", overrun, 1'b0);

      // full run with varied data against the reference model
      s_base = slide_cnt;
      e_base = enr_cnt;
      do_start("run4_start");
      serve(0, 11, 0, 1'b1, ab);
      for (int j = 0; j < N; j++)
         chkw($sformatf("model_slot%0d", j), 32'(slot(j)), 32'(expv(j, 11)));
      chkw("run4_slides", slide_cnt - s_base, N - 1);
      chkw("run4_en_reads", enr_cnt - e_base, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
